// File: rtl/data_mem_responder.sv
// Data-memory responder: per-lane valid/ready FSMs over a shared array, round-robin grant of up to NUM_PORTS lanes per cycle.
// Define DATA_MEM_RESPONDER_STATS_EN to add saturating stat_reads/stat_writes grant counters.
module data_mem_lane #(
  parameter int DW           = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          read_valid,
  input  logic          write_valid,
  input  logic          grant,
  input  logic [DW-1:0] word,
  output logic          pending,
  output logic          read_ready,
  output logic          write_ready,
  output logic [DW-1:0] read_data
);
  localparam int CW = $clog2(READ_LATENCY + 1);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, RESPOND = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          is_read, abort, op_valid;

  assign op_valid    = is_read ? read_valid : write_valid;
  assign pending     = (state == IDLE) && (read_valid || write_valid);
  assign read_ready  = (state == RESPOND) && is_read;
  assign write_ready = (state == RESPOND) && !is_read;

  // Writes commit at the grant edge and respond immediately; reads wait out the latency in BUSY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      is_read   <= 1'b0;
      abort     <= 1'b0;
      read_data <= '0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          is_read <= read_valid;
          abort   <= 1'b0;
          if (read_valid) begin
            read_data <= word;
            cnt       <= CW'(READ_LATENCY - 1);
            state     <= (READ_LATENCY == 1) ? RESPOND : BUSY;
          end else begin
            state <= RESPOND;
          end
        end
        BUSY: begin
          abort <= abort | !op_valid;
          if (cnt <= CW'(1)) state <= (abort || !op_valid) ? IDLE : RESPOND;
          else               cnt   <= cnt - 1'b1;
        end
        RESPOND: if (!op_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

module data_mem_responder #(
  parameter int DATA_MEM_ADDR_BITS = 8,
  parameter int DATA_MEM_DATA_BITS = 8,
  parameter int NUM_LANES          = 2,
  parameter int NUM_PORTS          = 1,
  parameter int READ_LATENCY       = 2
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NUM_LANES-1:0]                          mem_read_valid,
  input  logic [NUM_LANES-1:0][DATA_MEM_ADDR_BITS-1:0]  mem_read_address,
  output logic [NUM_LANES-1:0]                          mem_read_ready,
  output logic [NUM_LANES-1:0][DATA_MEM_DATA_BITS-1:0]  mem_read_data,
  input  logic [NUM_LANES-1:0]                          mem_write_valid,
  input  logic [NUM_LANES-1:0][DATA_MEM_ADDR_BITS-1:0]  mem_write_address,
  input  logic [NUM_LANES-1:0][DATA_MEM_DATA_BITS-1:0]  mem_write_data,
  output logic [NUM_LANES-1:0]                          mem_write_ready,
  input  logic                                          init_write_enable,
  input  logic [DATA_MEM_ADDR_BITS-1:0]                 init_address,
  input  logic [DATA_MEM_DATA_BITS-1:0]                 init_data
`ifdef DATA_MEM_RESPONDER_STATS_EN
  ,
  output logic [15:0]                                   stat_reads,
  output logic [15:0]                                   stat_writes
`endif
);
  localparam int AW = DATA_MEM_ADDR_BITS;
  localparam int DW = DATA_MEM_DATA_BITS;
  localparam int PW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [DW-1:0]                mem [2**AW];
  logic [NUM_LANES-1:0]         pending, grant, grant_rd, grant_wr;
  logic [NUM_LANES-1:0][DW-1:0] word;
  logic [PW-1:0]                rr_ptr, last, li;
  int                           n_grant;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign word[i] = mem[mem_read_address[i]];
    data_mem_lane #(.DW(DW), .READ_LATENCY(READ_LATENCY)) u_lane (
      .clk         (clk),
      .reset       (reset),
      .read_valid  (mem_read_valid[i]),
      .write_valid (mem_write_valid[i]),
      .grant       (grant[i]),
      .word        (word[i]),
      .pending     (pending[i]),
      .read_ready  (mem_read_ready[i]),
      .write_ready (mem_write_ready[i]),
      .read_data   (mem_read_data[i])
    );
  end

  always_comb begin
    grant   = '0;
    n_grant = 0;
    last    = rr_ptr;
    li      = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      li = PW'((int'(rr_ptr) + k) % NUM_LANES);
      if (pending[li] && n_grant < NUM_PORTS) begin
        grant[li] = 1'b1;
        n_grant++;
        last = li;
      end
    end
  end

  assign grant_rd = grant & mem_read_valid;
  assign grant_wr = grant & ~mem_read_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      rr_ptr <= '0;
    else if (|grant) rr_ptr <= (int'(last) + 1 >= NUM_LANES) ? '0 : last + 1'b1;
  end

  // Ascending lane order lets the higher lane win a write collision; init goes last and beats both.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++)
      if (reset && grant_wr[i]) mem[mem_write_address[i]] <= mem_write_data[i];
    if (init_write_enable) mem[init_address] <= init_data;
  end

`ifdef DATA_MEM_RESPONDER_STATS_EN
  function automatic logic [15:0] sat_add(input logic [15:0] a, input int n);
    int s;
    s = int'(a) + n;
    return (s > 65535) ? 16'hFFFF : 16'(s);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_reads  <= '0;
      stat_writes <= '0;
    end else begin
      stat_reads  <= sat_add(stat_reads,  $countones(grant_rd));
      stat_writes <= sat_add(stat_writes, $countones(grant_wr));
    end
  end
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: dut 0 has one port (arbitration), dut 1 has two (same-cycle collisions).
module tb_data_mem_responder;
  logic clk = 1'b0, reset = 1'b0;
  logic [1:0]      rv [2], wv [2], rr [2], wr [2];
  logic [1:0][7:0] ra [2], wa [2], wd [2], rdat [2];
  logic            iwe [2];
  logic [7:0]      ia [2], id [2];
`ifdef DATA_MEM_RESPONDER_STATS_EN
  logic [15:0]     sr [2], sw [2];
`endif
  logic [7:0] q0[$], q1[$];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.NUM_PORTS(1)) dut (
    .clk(clk), .reset(reset),
    .mem_read_valid(rv[0]), .mem_read_address(ra[0]), .mem_read_ready(rr[0]), .mem_read_data(rdat[0]),
    .mem_write_valid(wv[0]), .mem_write_address(wa[0]), .mem_write_data(wd[0]), .mem_write_ready(wr[0]),
    .init_write_enable(iwe[0]), .init_address(ia[0]), .init_data(id[0])
`ifdef DATA_MEM_RESPONDER_STATS_EN
    , .stat_reads(sr[0]), .stat_writes(sw[0])
`endif
  );

  data_mem_responder #(.NUM_PORTS(2)) dut2 (
    .clk(clk), .reset(reset),
    .mem_read_valid(rv[1]), .mem_read_address(ra[1]), .mem_read_ready(rr[1]), .mem_read_data(rdat[1]),
    .mem_write_valid(wv[1]), .mem_write_address(wa[1]), .mem_write_data(wd[1]), .mem_write_ready(wr[1]),
    .init_write_enable(iwe[1]), .init_address(ia[1]), .init_data(id[1])
`ifdef DATA_MEM_RESPONDER_STATS_EN
    , .stat_reads(sr[1]), .stat_writes(sw[1])
`endif
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic preload(input int d, input logic [7:0] a, input logic [7:0] v);
    iwe[d] = 1'b1; ia[d] = a; id[d] = v;
    tick();
    iwe[d] = 1'b0;
  endtask

  function automatic logic [7:0] pop(input int lane);
    if (lane == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic read_lane(input int d, input int lane, input logic [7:0] a, input logic [7:0] e);
    int n;
    logic [7:0] x;
    if (lane == 0) q0.push_back(e); else q1.push_back(e);
    rv[d][lane] = 1'b1; ra[d][lane] = a; n = 0;
    do begin tick(); n++; end while (!rr[d][lane] && n < 16);
    x = pop(lane);
    tests++;
    if (rr[d][lane] !== 1'b1) begin
      fails++; $display("FAIL rd_ready_timeout d%0d lane%0d addr %h", d, lane, a);
    end else begin
      tests++;
      if (rdat[d][lane] !== x) begin
        fails++; $display("FAIL rd_data d%0d lane%0d addr %h got %h exp %h", d, lane, a, rdat[d][lane], x);
      end
    end
    rv[d][lane] = 1'b0;
    tick();
    tests++;
    if (rr[d][lane] !== 1'b0) begin fails++; $display("FAIL rd_ready_fall d%0d lane%0d got %b exp 0", d, lane, rr[d][lane]); end
  endtask

  task automatic write_lane(input int d, input int lane, input logic [7:0] a, input logic [7:0] v);
    int n;
    wv[d][lane] = 1'b1; wa[d][lane] = a; wd[d][lane] = v; n = 0;
    do begin tick(); n++; end while (!wr[d][lane] && n < 16);
    tests++;
    if (wr[d][lane] !== 1'b1) begin fails++; $display("FAIL wr_ready_timeout d%0d lane%0d", d, lane); end
    wv[d][lane] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    tests++;
    if (rr[0] !== 2'b00 || wr[0] !== 2'b00) begin
      fails++; $display("FAIL reset_ready got rd %b wr %b exp 00 00", rr[0], wr[0]);
    end
    tests++;
    if (rdat[0] !== 16'h0000) begin fails++; $display("FAIL reset_data got %h exp 0000", rdat[0]); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_read_latency();
    logic [7:0] x;
    preload(0, 8'h10, 8'hA5);
    q0.push_back(8'hA5);
    rv[0][0] = 1'b1; ra[0][0] = 8'h10;
    tick();
    tests++;
    if (rr[0][0] !== 1'b0) begin fails++; $display("FAIL lat_early got %b exp 0", rr[0][0]); end
    tick();
    x = pop(0);
    tests++;
    if (rr[0][0] !== 1'b1) begin fails++; $display("FAIL lat_ready got %b exp 1", rr[0][0]); end
    tests++;
    if (rdat[0][0] !== x) begin fails++; $display("FAIL lat_data got %h exp %h", rdat[0][0], x); end
    rv[0][0] = 1'b0;
    tests++;
    if (rr[0][0] !== 1'b1) begin fails++; $display("FAIL lat_hold got %b exp 1", rr[0][0]); end
    tick();
    tests++;
    if (rr[0][0] !== 1'b0) begin fails++; $display("FAIL lat_fall got %b exp 0", rr[0][0]); end
  endtask

  task automatic test_write_read();
    wv[0][1] = 1'b1; wa[0][1] = 8'h20; wd[0][1] = 8'h3C;
    tick();
    tests++;
    if (wr[0][1] !== 1'b1) begin fails++; $display("FAIL wr_latency got %b exp 1", wr[0][1]); end
    wv[0][1] = 1'b0;
    tick();
    tests++;
    if (wr[0][1] !== 1'b0) begin fails++; $display("FAIL wr_fall got %b exp 0", wr[0][1]); end
    read_lane(0, 1, 8'h20, 8'h3C);
  endtask

  task automatic burst(input int first);
    logic [1:0] e1;
    logic [7:0] x0, x1;
    e1 = (first == 0) ? 2'b01 : 2'b10;
    q0.push_back(8'h11); q1.push_back(8'h22);
    rv[0] = 2'b11; ra[0][0] = 8'h30; ra[0][1] = 8'h31;
    tick(); tick();
    tests++;
    if (rr[0] !== e1) begin fails++; $display("FAIL rr_first got %b exp %b", rr[0], e1); end
    tick();
    tests++;
    if (rr[0] !== 2'b11) begin fails++; $display("FAIL rr_second got %b exp 11", rr[0]); end
    x0 = pop(0); x1 = pop(1);
    tests++;
    if (rdat[0][0] !== x0 || rdat[0][1] !== x1) begin
      fails++; $display("FAIL rr_data got %h %h exp %h %h", rdat[0][0], rdat[0][1], x0, x1);
    end
    rv[0] = 2'b00;
    tick();
    tests++;
    if (rr[0] !== 2'b00) begin fails++; $display("FAIL rr_fall got %b exp 00", rr[0]); end
  endtask

  task automatic test_round_robin();
    preload(0, 8'h30, 8'h11);
    preload(0, 8'h31, 8'h22);
    burst(0);
    read_lane(0, 0, 8'h10, 8'hA5);
    burst(1);
  endtask

  task automatic test_collision();
    logic [7:0] x;
    preload(1, 8'h40, 8'h55);
    q1.push_back(8'h55);
    wv[1][0] = 1'b1; wa[1][0] = 8'h40; wd[1][0] = 8'h77;
    rv[1][1] = 1'b1; ra[1][1] = 8'h40;
    tick();
    tests++;
    if (wr[1][0] !== 1'b1) begin fails++; $display("FAIL col_wr got %b exp 1", wr[1][0]); end
    tick();
    x = pop(1);
    tests++;
    if (rr[1][1] !== 1'b1 || rdat[1][1] !== x) begin
      fails++; $display("FAIL col_old got rdy %b data %h exp 1 %h", rr[1][1], rdat[1][1], x);
    end
    wv[1] = 2'b00; rv[1] = 2'b00;
    tick();
    read_lane(1, 1, 8'h40, 8'h77);
    wv[1] = 2'b11; wa[1][0] = 8'h41; wa[1][1] = 8'h41; wd[1][0] = 8'hAA; wd[1][1] = 8'hBB;
    tick();
    tests++;
    if (wr[1] !== 2'b11) begin fails++; $display("FAIL ww_grant got %b exp 11", wr[1]); end
    wv[1] = 2'b00;
    tick();
    read_lane(1, 0, 8'h41, 8'hBB);
    wv[1][0] = 1'b1; wa[1][0] = 8'h42; wd[1][0] = 8'hDD;
    iwe[1] = 1'b1; ia[1] = 8'h42; id[1] = 8'hCC;
    tick();
    iwe[1] = 1'b0;
    tests++;
    if (wr[1][0] !== 1'b1) begin fails++; $display("FAIL init_wr got %b exp 1", wr[1][0]); end
    wv[1][0] = 1'b0;
    tick();
    read_lane(1, 0, 8'h42, 8'hCC);
  endtask

  task automatic test_drop_busy();
    rv[0][0] = 1'b1; ra[0][0] = 8'h30;
    tick();
    rv[0][0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (rr[0][0] !== 1'b0) begin fails++; $display("FAIL drop_ready cyc%0d got %b exp 0", i, rr[0][0]); end
    end
    read_lane(0, 0, 8'h30, 8'h11);
  endtask

  task automatic test_reset_respond();
    int n;
    rv[0][0] = 1'b1; ra[0][0] = 8'h10; n = 0;
    do begin tick(); n++; end while (!rr[0][0] && n < 16);
    tests++;
    if (rr[0][0] !== 1'b1) begin fails++; $display("FAIL rst_pre_ready got %b exp 1", rr[0][0]); end
    reset = 1'b0;
    #1;
    tests++;
    if (rr[0][0] !== 1'b0 || rdat[0][0] !== 8'h00) begin
      fails++; $display("FAIL rst_async got rdy %b data %h exp 0 00", rr[0][0], rdat[0][0]);
    end
    rv[0][0] = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_post_reset();
`ifdef DATA_MEM_RESPONDER_STATS_EN
    tests++;
    if (sr[0] !== 16'd0 || sw[0] !== 16'd0) begin
      fails++; $display("FAIL stat_clear got %0d %0d exp 0 0", sr[0], sw[0]);
    end
`endif
    read_lane(0, 0, 8'h10, 8'hA5);
    read_lane(0, 1, 8'h20, 8'h3C);
    write_lane(0, 0, 8'h50, 8'h01);
    write_lane(0, 1, 8'h51, 8'h02);
    read_lane(0, 0, 8'h51, 8'h02);
`ifdef DATA_MEM_RESPONDER_STATS_EN
    tests++;
    if (sr[0] !== 16'd3 || sw[0] !== 16'd2) begin
      fails++; $display("FAIL stat_count got rd %0d wr %0d exp 3 2", sr[0], sw[0]);
    end
`endif
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rv[d] = '0; wv[d] = '0; ra[d] = '0; wa[d] = '0; wd[d] = '0;
      iwe[d] = 1'b0; ia[d] = '0; id[d] = '0;
    end
    test_reset();
    test_read_latency();
    test_write_read();
    test_round_robin();
    test_collision();
    test_drop_busy();
    test_reset_respond();
    test_post_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d tests", tests);
    $fatal(1);
  end
endmodule
